// File: rtl/turbo_afu_pkg.sv
// Shared definitions for the turbo AFU return path: CL header flags,
// header field widths and the packer FSM states.
package turbo_afu_pkg;

  localparam int FLAG_W = 2;

  localparam logic [FLAG_W-1:0] FLG_START = 2'b10;
  localparam logic [FLAG_W-1:0] FLG_BODY  = 2'b00;
  localparam logic [FLAG_W-1:0] FLG_END   = 2'b01;
  localparam logic [FLAG_W-1:0] FLG_SE    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } st2bus_state_e;

  function automatic logic [FLAG_W-1:0] cl_flag(input logic first, input logic last);
    case ({first, last})
      2'b10:   cl_flag = FLG_START;
      2'b01:   cl_flag = FLG_END;
      2'b11:   cl_flag = FLG_SE;
      default: cl_flag = FLG_BODY;
    endcase
  endfunction

endpackage

// File: rtl/st2bus_outreg.sv
// One-entry valid/ready holding register for the outgoing CL.
// free_o is high when a new CL may be loaded this cycle.
module st2bus_outreg #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         free_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // Data stays put until the consumer takes it; a load may coincide with a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/st2bus.sv
// Packs Avalon-ST words lowest-first into 512-bit CLs with a {flag, length}
// header; one CL buffered at the output plus one completing in the accumulator.
module st2bus
  import turbo_afu_pkg::*;
#(
  parameter int BUS         = 512,
  parameter int BUS_HEAD    = 8,
  parameter int BUS_PAYLOAD = 504,
  parameter int ST          = 24,
  parameter int W_CL_CNT    = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ST-1:0]       st_data,
  input  logic                st_valid,
  input  logic                st_sop,
  input  logic                st_eop,
  output logic                st_ready,
  output logic [BUS-1:0]      bus_data,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                frm_done,
  output logic [W_CL_CNT-1:0] cl_cnt,
  output logic                err_pulse
);

  localparam int WPC      = BUS_PAYLOAD / ST;
  localparam int WIDX_W   = $clog2(WPC + 1);
  localparam int LEN_W    = BUS_HEAD - FLAG_W;
  localparam int ST_BYTES = ST / 8;

  st2bus_state_e state_q, state_d;

  logic [BUS_PAYLOAD-1:0] pay_q, pay_n, pay_d;
  logic [WIDX_W-1:0]      widx_q, widx_n, widx_d;
  logic                   first_q, first_n, first_d;
  logic                   eop_q, eop_n, eop_d;
  logic                   st_ready_q, ready_d;
  logic                   frm_done_q, err_q;
  logic [W_CL_CNT-1:0]    cl_cnt_q;

  logic           acc_s, xfer_s, free_s, wr_s, start_s, err_s, close_s, load_s;
  logic [LEN_W-1:0] len_s;
  logic [BUS-1:0] cl_s;

  assign acc_s  = st_valid && st_ready_q;
  assign xfer_s = bus_valid && bus_ready;

  // State and accumulator registers plus registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pay_q      <= '0;
      widx_q     <= '0;
      first_q    <= 1'b0;
      eop_q      <= 1'b0;
      st_ready_q <= 1'b0;
      frm_done_q <= 1'b0;
      err_q      <= 1'b0;
      cl_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      widx_q     <= widx_d;
      first_q    <= first_d;
      eop_q      <= eop_d;
      st_ready_q <= ready_d;
      frm_done_q <= xfer_s && bus_data[BUS_PAYLOAD+LEN_W];
      err_q      <= err_s;
      if (start_s) begin
        cl_cnt_q <= '0;
      end else if (xfer_s) begin
        cl_cnt_q <= cl_cnt_q + W_CL_CNT'(1);
      end
    end
  end

  // Next state: a closing CL either goes straight out or parks in HOLD.
  always_comb begin
    state_d = state_q;
    wr_s    = 1'b0;
    start_s = 1'b0;
    err_s   = 1'b0;
    close_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_s && st_sop) begin
          start_s = 1'b1;
          wr_s    = 1'b1;
          close_s = st_eop || (WPC == 1);
        end else begin
          err_s = acc_s;
        end
      end
      S_FILL: begin
        if (acc_s) begin
          wr_s    = 1'b1;
          err_s   = st_sop;
          close_s = st_eop || (widx_q == WIDX_W'(WPC - 1));
        end else begin
          wr_s = 1'b0;
        end
      end
      default: ;
    endcase
    if (state_q == S_HOLD) begin
      if (free_s) begin
        state_d = eop_q ? S_IDLE : S_FILL;
      end else begin
        state_d = S_HOLD;
      end
    end else if (close_s) begin
      if (!free_s) begin
        state_d = S_HOLD;
      end else begin
        state_d = st_eop ? S_IDLE : S_FILL;
      end
    end else if (start_s) begin
      state_d = S_FILL;
    end else begin
      state_d = state_q;
    end
  end

  // Accumulator update, CL assembly and output-register load.
  always_comb begin
    pay_n   = pay_q;
    widx_n  = widx_q;
    first_n = first_q;
    eop_n   = eop_q;
    if (wr_s) begin
      pay_n[int'(widx_q)*ST +: ST] = st_data;
      widx_n  = widx_q + WIDX_W'(1);
      eop_n   = st_eop;
      first_n = first_q || start_s;
    end else begin
      widx_n = widx_q;
    end
    load_s = free_s && (close_s || (state_q == S_HOLD));
    len_s  = LEN_W'(int'(widx_n) * ST_BYTES);
    cl_s   = '0;
    cl_s[BUS_PAYLOAD +: BUS_HEAD] = {cl_flag(first_n, eop_n), len_s};
    cl_s[BUS_PAYLOAD-1:0]         = pay_n;
    if (load_s) begin
      pay_d   = '0;
      widx_d  = '0;
      first_d = 1'b0;
      eop_d   = 1'b0;
    end else begin
      pay_d   = pay_n;
      widx_d  = widx_n;
      first_d = first_n;
      eop_d   = eop_n;
    end
    ready_d = (state_d != S_HOLD);
  end

  st2bus_outreg #(.W(BUS)) u_outreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_s),
    .data_i (cl_s),
    .ready_i(bus_ready),
    .data_o (bus_data),
    .valid_o(bus_valid),
    .free_o (free_s)
  );

  assign st_ready  = st_ready_q;
  assign frm_done  = frm_done_q;
  assign err_pulse = err_q;
  assign cl_cnt    = cl_cnt_q;

endmodule
